// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Pipelined ShiftRows / InvShiftRows stage for Rijndael states of 4, 6 or 8
// columns. The direction is chosen per beat by in_inv and travels with the
// data, so one instance serves both the encrypt and decrypt datapaths.
//
// The byte permutation is pure wiring applied to in_data before capture.
// Storage is a two-entry skid buffer: the main register (M) drives the
// outputs, and the skid register (S) catches one beat while M is stalled.
// in_ready is a flop, so there is no combinational path from out_ready to
// in_ready.
//
// State layout: column c occupies bits [32*NB-1-32c -: 32]. Row r of that
// column is byte [32*NB-1-32c-8r -: 8] (column-major, MSB first).
//
// Parameters
//   NB        number of state columns (4, 6 or 8)
//   CNT_W     width of the completed-output-beat counter
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous clear of buffered beats (beat_cnt is kept)
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid & in_ready
//   in_data    in   input state, 32*NB bits
//   in_inv     in   0 = ShiftRows, 1 = InvShiftRows, sampled with the beat
//   out_valid  out  output beat valid
//   out_ready  in   downstream accept
//   out_data   out  permuted state, 32*NB bits
//   out_inv    out  in_inv of the beat on out_data
//   beat_cnt   out  count of completed output handshakes, wraps
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_inv,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int W = 32 * NB;

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    // Row rotation amount. Only the 256-bit block uses the wider 0/1/3/4
    // offsets; the 128- and 192-bit blocks rotate row r by r columns.
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Permutation (wiring only)
    // -------------------------------------------------------------------------
    logic [W-1:0] fwd_data;
    logic [W-1:0] inv_data;
    logic [W-1:0] perm_data;

    // NOTE: every signal written in an always_comb gets a default before any
    // conditional or partial assignment, so no path leaves it holding its old
    // value and no latch is inferred.
    always_comb begin
        fwd_data = '0;
        inv_data = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                fwd_data[W-8-32*c-8*r +: 8] =
                    in_data[W-8-32*((c + row_shift(r)) % NB)-8*r +: 8];
                inv_data[W-8-32*c-8*r +: 8] =
                    in_data[W-8-32*((c - row_shift(r) + NB) % NB)-8*r +: 8];
            end
        end
        perm_data = in_inv ? inv_data : fwd_data;
    end

    // -------------------------------------------------------------------------
    // Skid buffer control
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // M empty, S empty
        ST_ONE   = 2'd1,  // M full,  S empty
        ST_FULL  = 2'd2   // M full,  S full
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     m_data_q, m_data_d;
    logic             m_inv_q, m_inv_d;
    logic [W-1:0]     s_data_q, s_data_d;
    logic             s_inv_q, s_inv_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic accept;
    logic pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = m_data_q;
    assign out_inv   = m_inv_q;
    assign in_ready  = in_ready_q;
    assign beat_cnt  = beat_cnt_q;

    // A beat offered during flush is dropped, so it is never accepted.
    assign accept = in_valid & in_ready_q & ~flush;
    // The output handshake still completes (and counts) during flush.
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_inv_d  = m_inv_q;
        s_data_d = s_data_q;
        s_inv_d  = s_inv_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_data_d = perm_data;
                    m_inv_d  = in_inv;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    // Simultaneous in and out: M is replaced, no bubble.
                    m_data_d = perm_data;
                    m_inv_d  = in_inv;
                end else if (accept) begin
                    s_data_d = perm_data;
                    s_inv_d  = in_inv;
                    state_d  = ST_FULL;
                end else if (pop) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (pop) begin
                    m_data_d = s_data_q;
                    m_inv_d  = s_inv_q;
                    state_d  = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
        end

        // in_ready is a registered copy of "S will be empty next cycle".
        in_ready_d = (state_d != ST_FULL);
        beat_cnt_d = beat_cnt_q + CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d input regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            m_data_q   <= '0;
            m_inv_q    <= 1'b0;
            in_ready_q <= 1'b1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_inv_q    <= m_inv_d;
            in_ready_q <= in_ready_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // NOTE: the skid payload is never observed unless state says S is valid,
    // so it is left out of reset; only control and the visible M outputs reset.
    always_ff @(posedge clk) begin
        s_data_q <= s_data_d;
        s_inv_q  <= s_inv_d;
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- DUT A: NB=4, CNT_W=4 ----------------
    logic         flush_a = 1'b0, in_valid_a = 1'b0, in_inv_a = 1'b0, out_ready_a = 1'b0;
    logic [127:0] in_data_a = '0;
    logic         in_ready_a, out_valid_a, out_inv_a;
    logic [127:0] out_data_a;
    logic [3:0]   beat_cnt_a;

    shift_rows_pipe #(.NB(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_inv(in_inv_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_inv(out_inv_a), .beat_cnt(beat_cnt_a)
    );

    // ---------------- DUT B (NB=8) and C (NB=6), default CNT_W ----------------
    logic         flush_bc = 1'b0, in_valid_bc = 1'b0, in_inv_bc = 1'b0, out_ready_bc = 1'b0;
    logic [255:0] in_data_b = '0;
    logic [191:0] in_data_c = '0;
    logic         in_ready_b, out_valid_b, out_inv_b;
    logic         in_ready_c, out_valid_c, out_inv_c;
    logic [255:0] out_data_b;
    logic [191:0] out_data_c;
    logic [31:0]  beat_cnt_b, beat_cnt_c;

    shift_rows_pipe #(.NB(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_bc),
        .in_valid(in_valid_bc), .in_ready(in_ready_b), .in_data(in_data_b), .in_inv(in_inv_bc),
        .out_valid(out_valid_b), .out_ready(out_ready_bc), .out_data(out_data_b),
        .out_inv(out_inv_b), .beat_cnt(beat_cnt_b)
    );

    shift_rows_pipe #(.NB(6)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush_bc),
        .in_valid(in_valid_bc), .in_ready(in_ready_c), .in_data(in_data_c), .in_inv(in_inv_bc),
        .out_valid(out_valid_c), .out_ready(out_ready_bc), .out_data(out_data_c),
        .out_inv(out_inv_c), .beat_cnt(beat_cnt_c)
    );

    // ---------------- Reference model ----------------
    // Straight from the rule: out(r,c) = in(r, (c +/- sh(r)) mod nb), with the
    // state occupying the low 32*nb bits of a 256-bit vector.
    function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input bit inv);
        int sh8 [4] = '{0, 1, 3, 4};
        logic [255:0] res;
        int sh;
        int src;
        res = '0;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh  = (nb == 8) ? sh8[r] : r;
                src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
                res[32*nb-8-32*c-8*r +: 8] = d[32*nb-8-32*src-8*r +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Two-deep FIFO model of DUT A plus its handshake counter.
    typedef struct {
        logic [127:0] data;
        logic         inv;
    } beat_t;
    beat_t q_a[$];
    int    exp_cnt_a = 0;
    int    n_bc = 0;

    // Applies this cycle's handshakes to the model, then advances one clock.
    task automatic tick_a();
        bit           acc;
        bit           pop;
        beat_t        b;
        logic [255:0] t;
        acc = in_valid_a && (q_a.size() < 2) && !flush_a;
        pop = (q_a.size() > 0) && out_ready_a;
        if (pop) begin
            void'(q_a.pop_front());
            exp_cnt_a = (exp_cnt_a + 1) % 16;
        end
        if (flush_a) begin
            q_a.delete();
        end else if (acc) begin
            t      = ref_perm(4, {128'b0, in_data_a}, in_inv_a);
            b.data = t[127:0];
            b.inv  = in_inv_a;
            q_a.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        q_a.delete();
        exp_cnt_a = 0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready_a); end
        checks++; if (out_data_a !== 128'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data_a); end
        checks++; if (out_inv_a !== 1'b0) begin failures++; $display("FAIL reset_out_inv: got %0b want 0", out_inv_a); end
        checks++; if (beat_cnt_a !== 4'd0) begin failures++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt_a); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        in_valid_a = 1'b1; in_inv_a = 1'b0; out_ready_a = 1'b0;
        in_data_a  = 128'hd42711aee0bf98f1b8b45de51e415230;
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL vec_fwd_valid: got %0b want 1", out_valid_a); end
        checks++; if (out_data_a !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin failures++; $display("FAIL vec_fwd_data: got %h want d4bf5d30e0b452aeb84111f11e2798e5", out_data_a); end
        checks++; if (out_inv_a !== 1'b0) begin failures++; $display("FAIL vec_fwd_inv: got %0b want 0", out_inv_a); end
        in_valid_a = 1'b1; in_inv_a = 1'b1; out_ready_a = 1'b1;
        in_data_a  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (out_data_a !== 128'hd42711aee0bf98f1b8b45de51e415230) begin failures++; $display("FAIL vec_inv_data: got %h want d42711aee0bf98f1b8b45de51e415230", out_data_a); end
        checks++; if (out_inv_a !== 1'b1) begin failures++; $display("FAIL vec_inv_inv: got %0b want 1", out_inv_a); end
        tick_a();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL vec_drain_valid: got %0b want 0", out_valid_a); end
        checks++; if (beat_cnt_a !== 4'd2) begin failures++; $display("FAIL vec_beat_cnt: got %0d want 2", beat_cnt_a); end

        for (int i = 0; i < 32; i++) in_data_b[255-8*i -: 8] = 8'(i);
        for (int i = 0; i < 24; i++) in_data_c[191-8*i -: 8] = 8'(i);
        in_valid_bc = 1'b1; in_inv_bc = 1'b0; out_ready_bc = 1'b1;
        checks++; if (in_ready_b !== 1'b1 || in_ready_c !== 1'b1) begin failures++; $display("FAIL vec_bc_in_ready: got %0b/%0b want 1/1", in_ready_b, in_ready_c); end
        @(posedge clk);
        #1;
        n_bc++;
        in_valid_bc = 1'b0;
        checks++; if (out_data_b[255 -: 32] !== 32'h00050e13) begin failures++; $display("FAIL vec_nb8_col0: got %h want 00050e13", out_data_b[255 -: 32]); end
        checks++; if (out_data_c[191 -: 32] !== 32'h00050a0f) begin failures++; $display("FAIL vec_nb6_col0: got %h want 00050a0f", out_data_c[191 -: 32]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_bc();
        logic [255:0] sb, sc, eb, ec;
        bit           inv;
        in_valid_bc = 1'b1; out_ready_bc = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sb = rand256();
            sc = {64'b0, rand256() >> 64};
            inv = 1'($urandom);
            in_data_b = sb; in_data_c = sc[191:0]; in_inv_bc = inv;
            @(posedge clk);
            #1;
            n_bc++;
            eb = ref_perm(8, sb, inv);
            ec = ref_perm(6, sc, inv);
            checks++; if (out_valid_b !== 1'b1 || out_data_b !== eb || out_inv_b !== inv) begin failures++; $display("FAIL rand_nb8[%0d]: got v=%0b i=%0b %h want v=1 i=%0b %h", i, out_valid_b, out_inv_b, out_data_b, inv, eb); end
            checks++; if (out_valid_c !== 1'b1 || out_data_c !== ec[191:0] || out_inv_c !== inv) begin failures++; $display("FAIL rand_nb6[%0d]: got v=%0b i=%0b %h want v=1 i=%0b %h", i, out_valid_c, out_inv_c, out_data_c, inv, ec[191:0]); end
        end
        in_valid_bc = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (beat_cnt_b !== 32'(n_bc) || beat_cnt_c !== 32'(n_bc)) begin failures++; $display("FAIL bc_beat_cnt: got %0d/%0d want %0d", beat_cnt_b, beat_cnt_c, n_bc); end
        checks++; if (out_valid_b !== 1'b0 || out_valid_c !== 1'b0) begin failures++; $display("FAIL bc_drained: got %0b/%0b want 0/0", out_valid_b, out_valid_c); end
    endtask

    task automatic test_roundtrip();
        logic [127:0] x, y;
        logic [255:0] ey;
        out_ready_a = 1'b1; in_valid_a = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = 128'(rand256());
            in_data_a = x; in_inv_a = 1'b0;
            tick_a();
            y  = out_data_a;
            ey = ref_perm(4, {128'b0, x}, 1'b0);
            if (i < 50) begin
                checks++; if (y !== ey[127:0]) begin failures++; $display("FAIL roundtrip_fwd[%0d]: got %h want %h", i, y, ey[127:0]); end
            end
            in_data_a = y; in_inv_a = 1'b1;
            tick_a();
            checks++; if (out_data_a !== x || out_inv_a !== 1'b1) begin failures++; $display("FAIL roundtrip[%0d]: got %h inv=%0b want %h inv=1", i, out_data_a, out_inv_a, x); end
        end
        in_valid_a = 1'b0;
        tick_a();
    endtask

    task automatic test_random_handshake();
        for (int i = 0; i < 600; i++) begin
            in_valid_a  = ($urandom_range(0, 99) < 60);
            out_ready_a = ($urandom_range(0, 99) < 55);
            flush_a     = ($urandom_range(0, 39) == 0);
            in_inv_a    = 1'($urandom);
            in_data_a   = 128'(rand256());
            checks++; if (out_valid_a !== (q_a.size() > 0)) begin failures++; $display("FAIL hs_out_valid[%0d]: got %0b want %0b", i, out_valid_a, q_a.size() > 0); end
            checks++; if (in_ready_a !== (q_a.size() < 2)) begin failures++; $display("FAIL hs_in_ready[%0d]: got %0b want %0b", i, in_ready_a, q_a.size() < 2); end
            checks++; if (beat_cnt_a !== 4'(exp_cnt_a)) begin failures++; $display("FAIL hs_beat_cnt[%0d]: got %0d want %0d", i, beat_cnt_a, exp_cnt_a); end
            if (q_a.size() > 0) begin
                checks++; if (out_data_a !== q_a[0].data || out_inv_a !== q_a[0].inv) begin failures++; $display("FAIL hs_data[%0d]: got %h inv=%0b want %h inv=%0b", i, out_data_a, out_inv_a, q_a[0].data, q_a[0].inv); end
            end
            tick_a();
        end
        in_valid_a = 1'b0; flush_a = 1'b0; out_ready_a = 1'b1;
        repeat (3) tick_a();
    endtask

    task automatic test_backpressure();
        logic [127:0] d [3];
        logic [255:0] e0, e1;
        int           cnt0;
        cnt0 = int'(beat_cnt_a);
        for (int k = 0; k < 3; k++) d[k] = 128'(rand256());
        e0 = ref_perm(4, {128'b0, d[0]}, 1'b0);
        e1 = ref_perm(4, {128'b0, d[1]}, 1'b1);
        out_ready_a = 1'b0; in_valid_a = 1'b1;
        in_data_a = d[0]; in_inv_a = 1'b0;
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL bp_ready_1st: got %0b want 1", in_ready_a); end
        tick_a();
        in_data_a = d[1]; in_inv_a = 1'b1;
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL bp_ready_2nd: got %0b want 1", in_ready_a); end
        tick_a();
        in_data_a = d[2]; in_inv_a = 1'b0;
        checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL bp_ready_full: got %0b want 0", in_ready_a); end
        tick_a();
        tick_a();
        checks++; if (in_ready_a !== 1'b0 || out_data_a !== e0[127:0]) begin failures++; $display("FAIL bp_stall_hold: got rdy=%0b %h want rdy=0 %h", in_ready_a, out_data_a, e0[127:0]); end
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        checks++; if (out_data_a !== e0[127:0] || out_inv_a !== 1'b0) begin failures++; $display("FAIL bp_out0: got %h inv=%0b want %h inv=0", out_data_a, out_inv_a, e0[127:0]); end
        tick_a();
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== e1[127:0] || out_inv_a !== 1'b1) begin failures++; $display("FAIL bp_out1: got v=%0b %h inv=%0b want v=1 %h inv=1", out_valid_a, out_data_a, out_inv_a, e1[127:0]); end
        tick_a();
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++; $display("FAIL bp_drained: got v=%0b rdy=%0b want v=0 rdy=1", out_valid_a, in_ready_a); end
        checks++; if (beat_cnt_a !== 4'((cnt0 + 2) % 16)) begin failures++; $display("FAIL bp_beat_cnt: got %0d want %0d", beat_cnt_a, (cnt0 + 2) % 16); end
    endtask

    task automatic test_flush();
        int cnt0;
        cnt0 = int'(beat_cnt_a);
        out_ready_a = 1'b0; in_valid_a = 1'b1;
        in_data_a = 128'h1111; tick_a();
        in_data_a = 128'h2222; tick_a();
        in_data_a = 128'h3333; flush_a = 1'b1;
        tick_a();
        flush_a = 1'b0; in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++; $display("FAIL flush_full: got v=%0b rdy=%0b want v=0 rdy=1", out_valid_a, in_ready_a); end
        checks++; if (beat_cnt_a !== 4'(cnt0)) begin failures++; $display("FAIL flush_cnt_kept: got %0d want %0d", beat_cnt_a, cnt0); end
        tick_a();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL flush_beat_lost: got %0b want 0", out_valid_a); end
        in_valid_a = 1'b1; in_data_a = 128'h4444; tick_a();
        in_valid_a = 1'b0; flush_a = 1'b1; out_ready_a = 1'b1;
        tick_a();
        flush_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || beat_cnt_a !== 4'((cnt0 + 1) % 16)) begin failures++; $display("FAIL flush_handshake: got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid_a, beat_cnt_a, (cnt0 + 1) % 16); end
    endtask

    task automatic test_async_reset();
        out_ready_a = 1'b0; in_valid_a = 1'b1; in_inv_a = 1'b1;
        in_data_a = 128'hdeadbeef_01020304_05060708_090a0b0c; tick_a();
        in_data_a = 128'hcafef00d_11121314_15161718_191a1b1c; tick_a();
        in_valid_a = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++; $display("FAIL async_rst_ctl: got v=%0b rdy=%0b want v=0 rdy=1", out_valid_a, in_ready_a); end
        checks++; if (out_data_a !== 128'h0 || out_inv_a !== 1'b0 || beat_cnt_a !== 4'd0) begin failures++; $display("FAIL async_rst_data: got %h inv=%0b cnt=%0d want 0 inv=0 cnt=0", out_data_a, out_inv_a, beat_cnt_a); end
        pulse_reset();
    endtask

    task automatic test_wrap();
        pulse_reset();
        in_valid_a = 1'b1; out_ready_a = 1'b1; in_inv_a = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            in_data_a = 128'(rand256());
            tick_a();
            checks++; if (out_valid_a !== 1'b1 || beat_cnt_a !== 4'((t - 1) % 16)) begin failures++; $display("FAIL wrap[%0d]: got v=%0b cnt=%0d want v=1 cnt=%0d", t, out_valid_a, beat_cnt_a, (t - 1) % 16); end
        end
        in_valid_a = 1'b0;
        tick_a();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random_bc();
        test_roundtrip();
        test_random_handshake();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
